// File: rtl/freq_meter_pkg.sv
`default_nettype none
//============================================================================
// freq_meter_pkg - shared encodings for the frequency-measurement chain (rev 1.0)
//============================================================================
package freq_meter_pkg;

  localparam int unsigned c_TIMER_W = 32;

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_CLEAR  = 3'd1;
  localparam logic [2:0] c_S_GATE   = 3'd2;
  localparam logic [2:0] c_S_SETTLE = 3'd3;
  localparam logic [2:0] c_S_STORE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = c_S_IDLE,
    ST_CLEAR  = c_S_CLEAR,
    ST_GATE   = c_S_GATE,
    ST_SETTLE = c_S_SETTLE,
    ST_STORE  = c_S_STORE
  } state_t;

  localparam logic [1:0] c_GSEL_1S    = 2'b00;
  localparam logic [1:0] c_GSEL_100MS = 2'b01;
  localparam logic [1:0] c_GSEL_10MS  = 2'b10;
  localparam logic [1:0] c_GSEL_1MS   = 2'b11;

  localparam int unsigned c_GDIV_1S    = 1;
  localparam int unsigned c_GDIV_100MS = 10;
  localparam int unsigned c_GDIV_10MS  = 100;
  localparam int unsigned c_GDIV_1MS   = 1000;

endpackage
`default_nettype wire

// File: rtl/gate_timer.sv
`default_nettype none
//============================================================================
// gate_timer - loadable down-counter with registered zero flag (rev 1.0)
//============================================================================
module gate_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] r_count;
  logic         r_zero;

  // r_zero tracks the value r_count will hold, so it is valid in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else if (load) begin
      r_count <= load_value;
      r_zero  <= (load_value == '0);
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
      r_zero  <= (r_count == W'(1));
    end
  end

  assign zero = r_zero;

endmodule
`default_nettype wire

// File: rtl/gate_sequencer.sv
`default_nettype none
//============================================================================
// gate_sequencer - clear/gate/settle/capture controller for the event counter (rev 1.0)
//============================================================================
module gate_sequencer
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [1:0]       gate_sel,
  output logic             cnt_clear,
  output logic             cnt_enable,
  input  logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_ovf,
  output logic [CNT_W-1:0] result,
  output logic             result_ovf,
  output logic [1:0]       result_gate,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam logic [c_TIMER_W-1:0] c_LOAD_1S    = 32'(CLK_FREQ / c_GDIV_1S    - 1);
  localparam logic [c_TIMER_W-1:0] c_LOAD_100MS = 32'(CLK_FREQ / c_GDIV_100MS - 1);
  localparam logic [c_TIMER_W-1:0] c_LOAD_10MS  = 32'(CLK_FREQ / c_GDIV_10MS  - 1);
  localparam logic [c_TIMER_W-1:0] c_LOAD_1MS   = 32'(CLK_FREQ / c_GDIV_1MS   - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_gate_q;
  logic                 w_latch_gate;
  logic                 w_capture;
  logic [c_TIMER_W-1:0] w_load_value;
  logic                 w_timer_zero;
  logic [CNT_W-1:0]     r_result;
  logic                 r_result_ovf;
  logic [1:0]           r_result_gate;
  logic                 r_result_valid;

  always_comb begin
    w_load_value = c_LOAD_1S;
    case (r_gate_q)
      c_GSEL_1S:    w_load_value = c_LOAD_1S;
      c_GSEL_100MS: w_load_value = c_LOAD_100MS;
      c_GSEL_10MS:  w_load_value = c_LOAD_10MS;
      c_GSEL_1MS:   w_load_value = c_LOAD_1MS;
      default:      w_load_value = c_LOAD_1S;
    endcase
  end

  gate_timer #(
    .W (c_TIMER_W)
  ) u_gate_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (r_state == ST_CLEAR),
    .load_value (w_load_value),
    .en         (r_state == ST_GATE),
    .zero       (w_timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_latch_gate = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start || continuous) begin
          w_state_nxt  = ST_CLEAR;
          w_latch_gate = 1'b1;
        end
      end
      ST_CLEAR:  w_state_nxt = ST_GATE;
      ST_GATE: begin
        if (w_timer_zero) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: w_state_nxt = ST_STORE;
      ST_STORE: begin
        // Holding here while the previous result is unread is what prevents drops
        if (!r_result_valid || result_ready) begin
          w_capture = 1'b1;
          if (continuous) begin
            w_state_nxt  = ST_CLEAR;
            w_latch_gate = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate_q       <= c_GSEL_1S;
      r_result       <= '0;
      r_result_ovf   <= 1'b0;
      r_result_gate  <= c_GSEL_1S;
      r_result_valid <= 1'b0;
    end else begin
      if (w_latch_gate) begin
        r_gate_q <= gate_sel;
      end
      if (w_capture) begin
        r_result       <= cnt_value;
        r_result_ovf   <= cnt_ovf;
        r_result_gate  <= r_gate_q;
        r_result_valid <= 1'b1;
      end else if (r_result_valid && result_ready) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign cnt_clear    = (r_state == ST_CLEAR);
  assign cnt_enable   = (r_state == ST_GATE);
  assign busy         = (r_state != ST_IDLE);
  assign result       = r_result;
  assign result_ovf   = r_result_ovf;
  assign result_gate  = r_result_gate;
  assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_sequencer.sv
`default_nettype none
//============================================================================
// tb_gate_sequencer - scoreboard bench with behavioural counter datapath (rev 1.0)
//============================================================================
module tb_gate_sequencer;

  localparam int CF = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [1:0]  gate_sel = 2'b00;
  logic        cnt_clear, cnt_enable, busy;
  logic [31:0] dp_cnt = '0;
  logic        dp_ovf = 1'b0;
  logic [31:0] result;
  logic        result_ovf, result_valid;
  logic [1:0]  result_gate;
  logic        result_ready = 1'b0;

  int   rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random
  bit   force_ovf = 1'b0;
  bit   abort_win = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic [1:0]  gate;
  } exp_t;
  exp_t sb[$];

  gate_sequencer #(.CLK_FREQ(CF), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .gate_sel     (gate_sel),
    .cnt_clear    (cnt_clear),
    .cnt_enable   (cnt_enable),
    .cnt_value    (dp_cnt),
    .cnt_ovf      (dp_ovf),
    .result       (result),
    .result_ovf   (result_ovf),
    .result_gate  (result_gate),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic int glen(input logic [1:0] code);
    int d = 1;
    for (int i = 0; i < int'(code); i++) d = d * 10;
    return CF / d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Event-counter datapath: one event per enabled cycle, sticky overflow on demand
  always @(posedge clk) begin
    if (cnt_clear) begin
      dp_cnt <= '0;
      dp_ovf <= 1'b0;
    end else if (cnt_enable) begin
      dp_cnt <= dp_cnt + 1;
      if (force_ovf) dp_ovf <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       result_ready = 1'b0;
      1:       result_ready = 1'b1;
      default: result_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every clear opens a window sized by the gate code seen just before it
  logic [1:0] gs_last = 2'b00;
  int         en_run = 0;
  int         exp_len = 0;
  bit         en_prev = 1'b0;
  bit         held = 1'b0;
  exp_t       last_out;
  exp_t       e;

  always @(negedge clk) begin
    if (cnt_clear) begin
      e.res  = 32'(glen(gs_last));
      e.ovf  = force_ovf;
      e.gate = gs_last;
      sb.push_back(e);
      exp_len = glen(gs_last);
    end
    gs_last = gate_sel;
    if (cnt_enable) begin
      en_run++;
    end else begin
      if (en_prev && !abort_win) chk("enable_len", en_run, exp_len);
      en_run = 0;
    end
    en_prev = cnt_enable;
    if (result_valid) begin
      if (held) begin
        chk("stable_result", result, last_out.res);
        chk("stable_ovf", {31'd0, result_ovf}, {31'd0, last_out.ovf});
        chk("stable_gate", {30'd0, result_gate}, {30'd0, last_out.gate});
      end
      last_out.res  = result;
      last_out.ovf  = result_ovf;
      last_out.gate = result_gate;
      if (result_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %0d expected no transfer", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("result_ovf", {31'd0, result_ovf}, {31'd0, e.ovf});
          chk("result_gate", {30'd0, result_gate}, {30'd0, e.gate});
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((busy || result_valid || sb.size() != 0) && c < maxc) begin
      tick();
      c++;
    end
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_sb_empty", sb.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {28'd0, cnt_clear, cnt_enable, busy, result_valid}, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_ovf_gate"}, {29'd0, result_ovf, result_gate}, 32'd0);
  endtask

  task automatic single_timing(input logic [1:0] code, input string tag);
    int first = -1;
    int en = 0;
    int g = glen(code);
    gate_sel = code;
    rdy_mode = 1;
    pulse_start();
    chk({tag, "_clear_c1"}, {31'd0, cnt_clear}, 32'd1);
    for (int c = 2; c <= g + 10; c++) begin
      tick();
      if (cnt_enable) en++;
      if (result_valid && first < 0) begin
        first = c;
        chk({tag, "_value"}, result, 32'(g));
      end
    end
    chk({tag, "_enable_cycles"}, en, 32'(g));
    chk({tag, "_valid_cycle"}, first, 32'(g + 4));
    wait_idle(200);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    int vcnt;
    repeat (3) tick();
    reset = 1'b0;
    chk_all_zero("reset");

    // 1,2: single shot timing for G = 10 and G = 1
    single_timing(2'b10, "t1");
    single_timing(2'b11, "t2");

    // 3: continuous with backpressure
    gate_sel = 2'b11;
    rdy_mode = 0;
    continuous = 1'b1;
    repeat (20) tick();
    chk("t3_busy", {31'd0, busy}, 32'd1);
    chk("t3_valid", {31'd0, result_valid}, 32'd1);
    chk("t3_stalled", {31'd0, cnt_enable}, 32'd0);
    rdy_mode = 1;
    tick();
    rdy_mode = 0;
    tick();
    chk("t3_recapture", {31'd0, result_valid}, 32'd1);
    repeat (3) tick();
    continuous = 1'b0;
    rdy_mode = 1;
    wait_idle(200);

    // 4: overflow passthrough, then a clean window
    gate_sel = 2'b11;
    force_ovf = 1'b1;
    pulse_start();
    wait_idle(200);
    force_ovf = 1'b0;
    pulse_start();
    wait_idle(200);

    // 5: reset in the middle of the gate window
    gate_sel = 2'b10;
    abort_win = 1'b1;
    pulse_start();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk_all_zero("t5");
    vcnt = 0;
    repeat (30) begin
      tick();
      if (result_valid || busy) vcnt++;
    end
    chk("t5_quiet", vcnt, 32'd0);
    abort_win = 1'b0;

    // 6: start and gate_sel change mid-window are ignored; continuous dropped
    gate_sel = 2'b10;
    continuous = 1'b1;
    tick();
    repeat (4) tick();
    gate_sel = 2'b00;
    continuous = 1'b0;
    pulse_start();
    wait_idle(200);
    vcnt = 0;
    repeat (20) begin
      tick();
      if (cnt_clear) vcnt++;
    end
    chk("t6_stays_idle", vcnt, 32'd0);

    // Randomized single shots with random ready
    rdy_mode = 2;
    for (int i = 0; i < 25; i++) begin
      gate_sel = (i == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      force_ovf = 1'($urandom_range(0, 1));
      pulse_start();
      wait_idle(3000);
      force_ovf = 1'b0;
    end

    // Randomized continuous run with gate_sel changing every cycle
    continuous = 1'b1;
    repeat (400) begin
      tick();
      gate_sel = 2'($urandom_range(1, 3));
    end
    continuous = 1'b0;
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
